// File: rtl/io_bridge_if.sv
// Processor/RAM/stream bundle for io_bridge.
//   cpu_*    : processor bus (address, rw, write data in, read data out)
//   ram_*    : RAM side (address, write enable, write data, read data)
//   tx_*     : outbound byte stream, bridge is the source
//   rx_*     : inbound byte stream, bridge is the sink
// slave  : the bridge's view
// master : the environment's view (CPU, RAM model, stream peers)
interface io_bridge_if;
  logic [7:0]  cpu_adrs;
  logic        cpu_rw;
  logic [7:0]  cpu_dout;
  logic [15:0] cpu_din;
  logic [7:0]  ram_adrs;
  logic        ram_rw;
  logic [7:0]  ram_din;
  logic [15:0] ram_dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport slave (
    input  cpu_adrs, cpu_rw, cpu_dout, ram_dout, tx_ready, rx_data, rx_valid,
    output cpu_din, ram_adrs, ram_rw, ram_din, tx_data, tx_valid, rx_ready
  );

  modport master (
    output cpu_adrs, cpu_rw, cpu_dout, ram_dout, tx_ready, rx_data, rx_valid,
    input  cpu_din, ram_adrs, ram_rw, ram_din, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/io_bridge.sv
// Memory-mapped I/O bridge. Addresses outside the 16-byte window at IO_BASE
// pass straight to RAM; inside the window a TX FIFO, a status register and a
// one-byte RX holding register are decoded locally.
// Ports:
//   clk_i : system clock, all state on posedge
//   clr_i : synchronous reset, active-high
//   bus   : io_bridge_if.slave (cpu_*, ram_*, tx_*, rx_*)
// Register map (offset within window):
//   0x0 W  TXDATA  push byte into TX FIFO
//   0x1 R  STATUS  {8'h00, 4'h0, ovf, rx_full, tx_full, tx_empty}
//   0x1 W  STATUS  bit3 = 1 clears ovf
//   0x2 R  RXDATA  {8'h00, rx_hold}, clears rx_full
module io_bridge #(
  parameter logic [7:0] IO_BASE    = 8'hF0,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       clr_i,
  io_bridge_if.slave bus
);

  localparam int         PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic        ovf_q, ovf_d;
  logic        rx_full_q, rx_full_d;
  logic [7:0]  rx_hold_q, rx_hold_d;
  logic        prev_rw_q, prev_rw_d;
  logic [7:0]  prev_adrs_q, prev_adrs_d;
  logic        prev_valid_q, prev_valid_d;

  logic        io_hit;
  logic [3:0]  offset;
  logic        new_access;
  logic        tx_empty, tx_full;
  logic        tx_pop, push_req, tx_push, ovf_set, ovf_clr, rx_pop, rx_cap;
  logic [15:0] io_rdata;

  assign io_hit = (bus.cpu_adrs[7:4] == IO_BASE[7:4]);
  assign offset = bus.cpu_adrs[3:0];

  // Side effects fire only on the first edge of a run of identical accesses.
  assign new_access = !prev_valid_q || (prev_rw_q != bus.cpu_rw)
                      || (prev_adrs_q != bus.cpu_adrs);

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign tx_empty = (wr_ptr_q == rd_ptr_q);
  assign tx_full  = (wr_ptr_q[PW] != rd_ptr_q[PW])
                    && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  assign tx_pop   = !tx_empty && bus.tx_ready;
  assign push_req = io_hit && bus.cpu_rw && (offset == 4'h0) && new_access;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign tx_push  = push_req && (!tx_full || tx_pop);
  assign ovf_set  = push_req && tx_full && !tx_pop;
  assign ovf_clr  = io_hit && bus.cpu_rw && (offset == 4'h1) && new_access
                    && bus.cpu_dout[3];
  assign rx_pop   = io_hit && !bus.cpu_rw && (offset == 4'h2) && new_access;
  assign rx_cap   = bus.rx_valid && !rx_full_q;

  always_comb begin
    io_rdata = 16'h0000;
    case (offset)
      4'h1:    io_rdata = {8'h00, 4'h0, ovf_q, rx_full_q, tx_full, tx_empty};
      4'h2:    io_rdata = {8'h00, rx_hold_q};
      default: io_rdata = 16'h0000;
    endcase
  end

  assign bus.cpu_din  = io_hit ? io_rdata : bus.ram_dout;
  assign bus.ram_adrs = bus.cpu_adrs;
  assign bus.ram_din  = bus.cpu_dout;
  assign bus.ram_rw   = bus.cpu_rw && !io_hit;
  assign bus.tx_valid = !tx_empty;
  assign bus.tx_data  = tx_empty ? 8'h00 : mem_q[rd_ptr_q[PW-1:0]];
  assign bus.rx_ready = !rx_full_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ovf_d        = ovf_q;
    rx_full_d    = rx_full_q;
    rx_hold_d    = rx_hold_q;
    prev_rw_d    = bus.cpu_rw;
    prev_adrs_d  = bus.cpu_adrs;
    prev_valid_d = 1'b1;

    if (tx_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (tx_push) wr_ptr_d = wr_ptr_q + PTR_ONE;

    // Set has priority over a same-cycle clear.
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;

    if (rx_pop) rx_full_d = 1'b0;
    if (rx_cap) begin
      rx_full_d = 1'b1;
      rx_hold_d = bus.rx_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ovf_q        <= 1'b0;
      rx_full_q    <= 1'b0;
      rx_hold_q    <= 8'h00;
      prev_rw_q    <= 1'b0;
      prev_adrs_q  <= 8'h00;
      prev_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ovf_q        <= ovf_d;
      rx_full_q    <= rx_full_d;
      rx_hold_q    <= rx_hold_d;
      prev_rw_q    <= prev_rw_d;
      prev_adrs_q  <= prev_adrs_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  // Storage is left uninitialised on reset; the pointers alone define contents.
  always_ff @(posedge clk_i) begin
    if (tx_push && !clr_i) mem_q[wr_ptr_q[PW-1:0]] <= bus.cpu_dout;
  end

endmodule

// File: tb/tb_io_bridge.sv
module tb_io_bridge;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  io_bridge_if bif();

  io_bridge #(.IO_BASE(8'hF0), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .clr_i (clr),
    .bus   (bif.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: queue of bytes for the FIFO, flags, and last access key.
  logic [7:0] tq[$];
  bit         m_ovf, m_rxf, m_pv;
  logic [7:0] m_hold;
  logic [8:0] m_key;

  function automatic logic [15:0] exp_status();
    return {8'h00, 4'h0, m_ovf, m_rxf, (tq.size() == DEPTH), (tq.size() == 0)};
  endfunction

  function automatic logic [15:0] exp_din();
    if (bif.cpu_adrs[7:4] == 4'hF) begin
      if (bif.cpu_adrs[3:0] == 4'h1) return exp_status();
      if (bif.cpu_adrs[3:0] == 4'h2) return {8'h00, m_hold};
      return 16'h0000;
    end
    return bif.ram_dout;
  endfunction

  // Advance model using current inputs, then clock the DUT.
  task automatic cycle();
    bit hit, newacc, pop;
    logic [3:0] off;
    hit    = (bif.cpu_adrs[7:4] == 4'hF);
    off    = bif.cpu_adrs[3:0];
    newacc = !m_pv || (m_key != {bif.cpu_rw, bif.cpu_adrs});
    if (clr) begin
      tq.delete();
      m_ovf = 0; m_rxf = 0; m_hold = 8'h00; m_pv = 0;
    end else begin
      pop = (tq.size() > 0) && bif.tx_ready;
      if (pop) void'(tq.pop_front());
      if (hit && bif.cpu_rw && off == 4'h1 && newacc && bif.cpu_dout[3]) m_ovf = 0;
      if (hit && bif.cpu_rw && off == 4'h0 && newacc) begin
        if (tq.size() < DEPTH) tq.push_back(bif.cpu_dout);
        else m_ovf = 1;
      end
      if (bif.rx_valid && !m_rxf) begin
        if (hit && !bif.cpu_rw && off == 4'h2 && newacc) m_rxf = 0;
        m_hold = bif.rx_data;
        m_rxf  = 1;
      end else if (hit && !bif.cpu_rw && off == 4'h2 && newacc) begin
        m_rxf = 0;
      end
      m_pv  = 1;
      m_key = {bif.cpu_rw, bif.cpu_adrs};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic rw, input logic [7:0] d);
    bif.cpu_adrs = a;
    bif.cpu_rw   = rw;
    bif.cpu_dout = d;
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    drive(8'h00, 1'b0, 8'h00);
    cycle();
    cycle();
    clr = 1'b0;
    drive(8'hF1, 1'b0, 8'h00);
    n_total++; if (bif.tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", bif.tx_valid); else n_pass++;
    n_total++; if (bif.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", bif.tx_data); else n_pass++;
    n_total++; if (bif.rx_ready !== 1'b1) $display("FAIL reset_rx_ready: got %b want 1", bif.rx_ready); else n_pass++;
    n_total++; if (bif.cpu_din !== 16'h0001) $display("FAIL reset_status: got %h want 0001", bif.cpu_din); else n_pass++;
  endtask

  task automatic test_passthrough();
    logic [15:0] rd;
    drive(8'h10, 1'b1, 8'hA5);
    n_total++; if (bif.ram_rw !== 1'b1) $display("FAIL pt_ram_rw: got %b want 1", bif.ram_rw); else n_pass++;
    n_total++; if (bif.ram_adrs !== 8'h10) $display("FAIL pt_ram_adrs: got %h want 10", bif.ram_adrs); else n_pass++;
    n_total++; if (bif.ram_din !== 8'hA5) $display("FAIL pt_ram_din: got %h want a5", bif.ram_din); else n_pass++;
    cycle();
    rd = 16'($urandom);
    bif.ram_dout = rd;
    drive(8'h10, 1'b0, 8'h00);
    n_total++; if (bif.cpu_din !== rd) $display("FAIL pt_cpu_din: got %h want %h", bif.cpu_din, rd); else n_pass++;
    n_total++; if (bif.ram_rw !== 1'b0) $display("FAIL pt_ram_rd: got %b want 0", bif.ram_rw); else n_pass++;
    cycle();
    drive(8'hF1, 1'b0, 8'h00);
    n_total++; if (bif.cpu_din !== 16'h0001) $display("FAIL pt_io_state: got %h want 0001", bif.cpu_din); else n_pass++;
  endtask

  task automatic test_io_isolation();
    bif.tx_ready = 1'b0;
    drive(8'hF0, 1'b1, 8'h3C);
    n_total++; if (bif.ram_rw !== 1'b0) $display("FAIL iso_ram_rw: got %b want 0", bif.ram_rw); else n_pass++;
    n_total++; if (bif.tx_valid !== 1'b0) $display("FAIL iso_no_fallthru: got %b want 0", bif.tx_valid); else n_pass++;
    cycle();
    drive(8'hF1, 1'b0, 8'h00);
    n_total++; if (bif.tx_valid !== 1'b1) $display("FAIL iso_tx_valid: got %b want 1", bif.tx_valid); else n_pass++;
    n_total++; if (bif.tx_data !== 8'h3C) $display("FAIL iso_tx_data: got %h want 3c", bif.tx_data); else n_pass++;
    n_total++; if (bif.cpu_din !== 16'h0000) $display("FAIL iso_status: got %h want 0000", bif.cpu_din); else n_pass++;
    bif.tx_ready = 1'b1;
    cycle();
    bif.tx_ready = 1'b0;
    n_total++; if (bif.tx_valid !== 1'b0) $display("FAIL iso_drained: got %b want 0", bif.tx_valid); else n_pass++;
  endtask

  task automatic test_held_write();
    drive(8'hF0, 1'b1, 8'h77);
    repeat (3) cycle();
    drive(8'hF1, 1'b0, 8'h00);
    n_total++; if (bif.tx_data !== 8'h77) $display("FAIL held_tx_data: got %h want 77", bif.tx_data); else n_pass++;
    n_total++; if (bif.cpu_din !== 16'h0000) $display("FAIL held_status: got %h want 0000", bif.cpu_din); else n_pass++;
    bif.tx_ready = 1'b1;
    cycle();
    bif.tx_ready = 1'b0;
    n_total++; if (bif.tx_valid !== 1'b0) $display("FAIL held_one_entry: got %b want 0", bif.tx_valid); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] ov [5];
    ov = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bif.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(8'hF0, 1'b1, ov[i]);
      cycle();
      drive(8'h00, 1'b0, 8'h00);
      cycle();
    end
    drive(8'hF1, 1'b0, 8'h00);
    n_total++; if (bif.cpu_din !== 16'h000A) $display("FAIL ovf_status: got %h want 000a", bif.cpu_din); else n_pass++;
    bif.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (bif.tx_data !== ov[i]) $display("FAIL ovf_drain%0d: got %h want %h", i, bif.tx_data, ov[i]); else n_pass++;
      cycle();
    end
    bif.tx_ready = 1'b0;
    n_total++; if (bif.tx_valid !== 1'b0) $display("FAIL ovf_dropped: got %b want 0", bif.tx_valid); else n_pass++;
    drive(8'hF1, 1'b1, 8'h08);
    cycle();
    drive(8'hF1, 1'b0, 8'h00);
    n_total++; if (bif.cpu_din !== 16'h0001) $display("FAIL ovf_clear: got %h want 0001", bif.cpu_din); else n_pass++;
  endtask

  task automatic test_full_pop();
    logic [7:0] exp [4];
    exp = '{8'hA2, 8'hA3, 8'hA4, 8'h66};
    bif.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(8'hF0, 1'b1, 8'hA1 + 8'(i));
      cycle();
      drive(8'h00, 1'b0, 8'h00);
      cycle();
    end
    drive(8'hF1, 1'b0, 8'h00);
    n_total++; if (bif.cpu_din !== 16'h0002) $display("FAIL fp_full: got %h want 0002", bif.cpu_din); else n_pass++;
    drive(8'hF0, 1'b1, 8'h66);
    bif.tx_ready = 1'b1;
    cycle();
    bif.tx_ready = 1'b0;
    drive(8'hF1, 1'b0, 8'h00);
    n_total++; if (bif.cpu_din !== 16'h0002) $display("FAIL fp_no_ovf: got %h want 0002", bif.cpu_din); else n_pass++;
    bif.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (bif.tx_data !== exp[i]) $display("FAIL fp_drain%0d: got %h want %h", i, bif.tx_data, exp[i]); else n_pass++;
      cycle();
    end
    bif.tx_ready = 1'b0;
  endtask

  task automatic test_rx();
    drive(8'h00, 1'b0, 8'h00);
    bif.rx_data  = 8'h7E;
    bif.rx_valid = 1'b1;
    cycle();
    bif.rx_valid = 1'b0;
    drive(8'hF1, 1'b0, 8'h00);
    n_total++; if (bif.rx_ready !== 1'b0) $display("FAIL rx_ready_low: got %b want 0", bif.rx_ready); else n_pass++;
    n_total++; if (bif.cpu_din !== 16'h0005) $display("FAIL rx_status: got %h want 0005", bif.cpu_din); else n_pass++;
    drive(8'hF2, 1'b0, 8'h00);
    n_total++; if (bif.cpu_din !== 16'h007E) $display("FAIL rx_data: got %h want 007e", bif.cpu_din); else n_pass++;
    cycle();
    n_total++; if (bif.rx_ready !== 1'b1) $display("FAIL rx_ready_back: got %b want 1", bif.rx_ready); else n_pass++;
    drive(8'h00, 1'b0, 8'h00);
    cycle();
    drive(8'hF2, 1'b0, 8'h00);
    n_total++; if (bif.cpu_din !== 16'h007E) $display("FAIL rx_stale: got %h want 007e", bif.cpu_din); else n_pass++;
    cycle();
  endtask

  task automatic test_clr();
    bif.tx_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(8'hF0, 1'b1, 8'hB1 + 8'(i));
      cycle();
      drive(8'h00, 1'b0, 8'h00);
      cycle();
    end
    n_total++; if (bif.tx_valid !== 1'b1) $display("FAIL clr_pre: got %b want 1", bif.tx_valid); else n_pass++;
    drive(8'hF0, 1'b1, 8'h99);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    n_total++; if (bif.tx_valid !== 1'b0) $display("FAIL clr_tx_valid: got %b want 0", bif.tx_valid); else n_pass++;
    n_total++; if (bif.rx_ready !== 1'b1) $display("FAIL clr_rx_ready: got %b want 1", bif.rx_ready); else n_pass++;
    cycle();
    n_total++; if (bif.tx_data !== 8'h99) $display("FAIL clr_rearm: got %h want 99", bif.tx_data); else n_pass++;
    drive(8'h00, 1'b0, 8'h00);
    bif.tx_ready = 1'b1;
    cycle();
    bif.tx_ready = 1'b0;
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(1, 0) == 0) begin
        r = int'($urandom_range(5, 0));
        if (r < 4)       bif.cpu_adrs = 8'hF0 + 8'(r);
        else if (r == 4) bif.cpu_adrs = {4'hF, 4'($urandom)};
        else             bif.cpu_adrs = 8'($urandom);
        bif.cpu_rw   = 1'($urandom);
        bif.cpu_dout = 8'($urandom);
      end
      bif.tx_ready = 1'($urandom);
      bif.rx_valid = 1'($urandom);
      bif.rx_data  = 8'($urandom);
      bif.ram_dout = 16'($urandom);
      clr = ($urandom_range(49, 0) == 0);
      #1;
      n_total++; if (bif.cpu_din !== exp_din()) $display("FAIL rnd_cpu_din it%0d: got %h want %h", it, bif.cpu_din, exp_din()); else n_pass++;
      n_total++; if (bif.ram_rw !== (bif.cpu_rw && bif.cpu_adrs[7:4] != 4'hF)) $display("FAIL rnd_ram_rw it%0d: got %b", it, bif.ram_rw); else n_pass++;
      n_total++; if (bif.ram_adrs !== bif.cpu_adrs || bif.ram_din !== bif.cpu_dout) $display("FAIL rnd_ram_pass it%0d: got %h/%h want %h/%h", it, bif.ram_adrs, bif.ram_din, bif.cpu_adrs, bif.cpu_dout); else n_pass++;
      n_total++; if (bif.tx_valid !== (tq.size() > 0)) $display("FAIL rnd_tx_valid it%0d: got %b want %b", it, bif.tx_valid, tq.size() > 0); else n_pass++;
      n_total++; if (bif.tx_data !== ((tq.size() > 0) ? tq[0] : 8'h00)) $display("FAIL rnd_tx_data it%0d: got %h", it, bif.tx_data); else n_pass++;
      n_total++; if (bif.rx_ready !== !m_rxf) $display("FAIL rnd_rx_ready it%0d: got %b want %b", it, bif.rx_ready, !m_rxf); else n_pass++;
      cycle();
    end
    clr = 1'b0;
  endtask

  initial begin
    bif.cpu_adrs = 8'h00;
    bif.cpu_rw   = 1'b0;
    bif.cpu_dout = 8'h00;
    bif.ram_dout = 16'h0000;
    bif.tx_ready = 1'b0;
    bif.rx_data  = 8'h00;
    bif.rx_valid = 1'b0;
    m_ovf = 0; m_rxf = 0; m_pv = 0; m_hold = 8'h00; m_key = 9'h000;
    #2;
    test_reset();
    test_passthrough();
    test_io_isolation();
    test_held_write();
    test_overflow();
    test_full_pop();
    test_rx();
    test_clr();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
